// File: rtl/fp_normalize_pack.sv
// fp_normalize_pack: multi-cycle normalize, round-to-nearest-even and IEEE-754 pack stage
module fp_normalize_pack #(
  parameter int N_float = 32,
  parameter int N_exp   = 8,
  parameter int N_mant  = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sign_in,
  input  logic [N_exp-1:0]    exp_in,
  input  logic [N_mant+4:0]   mant_in,
  output logic [N_float-1:0]  float_R,
  output logic                done,
  output logic                busy,
  output logic                overflow,
  output logic                underflow
);
  localparam int MW = N_mant + 5;
  localparam logic [N_exp:0] EMAX = {1'b0, {N_exp{1'b1}}};
  localparam logic [N_exp:0] ONE = (N_exp+1)'(1);
  typedef enum logic [2:0] {IDLE, CHECK, SHIFT_R, SHIFT_L, ROUND, RENORM, DONE} state_t;
  state_t state_q;
  logic sign_q, ov_q, uf_q;
  logic [N_exp:0] exp_q, exp_inc_d;
  logic [MW-1:0] mant_q, shr_d;
  logic inc_d;
  logic [MW-4:0] rnd_d;
  assign exp_inc_d = exp_q + ONE;
  assign shr_d = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
  assign inc_d = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
  assign rnd_d = mant_q[MW-1:3] + (MW-3)'(inc_d);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      float_R   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      ov_q      <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= state_q != IDLE;
      case (state_q)
        IDLE: if (start) begin
          sign_q  <= sign_in;
          exp_q   <= {1'b0, exp_in};
          mant_q  <= mant_in;
          ov_q    <= 1'b0;
          uf_q    <= 1'b0;
          state_q <= CHECK;
        end
        CHECK: if (mant_q == '0) begin
          sign_q  <= 1'b0;
          exp_q   <= '0;
          state_q <= DONE;
        end else begin
          state_q <= mant_q[MW-1] ? SHIFT_R : !mant_q[MW-2] ? SHIFT_L : ROUND;
        end
        SHIFT_R: begin
          exp_q   <= exp_inc_d;
          mant_q  <= (exp_inc_d == EMAX) ? '0 : shr_d;
          ov_q    <= exp_inc_d == EMAX;
          state_q <= (exp_inc_d == EMAX) ? DONE : ROUND;
        end
        SHIFT_L: if (exp_q == ONE) begin
          exp_q   <= '0;
          mant_q  <= '0;
          uf_q    <= 1'b1;
          state_q <= DONE;
        end else begin
          mant_q  <= mant_q << 1;
          exp_q   <= exp_q - ONE;
          state_q <= mant_q[MW-3] ? ROUND : SHIFT_L;
        end
        ROUND: begin
          mant_q[MW-1:3] <= rnd_d;
          state_q <= rnd_d[MW-4] ? RENORM : DONE;
        end
        RENORM: begin
          exp_q   <= exp_inc_d;
          mant_q  <= (exp_inc_d == EMAX) ? '0 : mant_q >> 1;
          ov_q    <= exp_inc_d == EMAX;
          state_q <= DONE;
        end
        DONE: begin
          float_R   <= {sign_q, exp_q[N_exp-1:0], mant_q[N_mant+2:3]};
          overflow  <= ov_q;
          underflow <= uf_q;
          done      <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_normalize_pack.sv
// tb_fp_normalize_pack: directed and random checks of fp_normalize_pack against an arithmetic model
module tb_fp_normalize_pack;
  logic clk = 0, rst = 1, start = 0, sign_in = 0;
  logic [7:0] exp_in = 0;
  logic [27:0] mant_in = 0;
  logic [31:0] float_R;
  logic done, busy, overflow, underflow;
  int n_assert = 0, n_fail = 0;

  fp_normalize_pack dut (
    .clk(clk), .rst(rst), .start(start), .sign_in(sign_in), .exp_in(exp_in),
    .mant_in(mant_in), .float_R(float_R), .done(done), .busy(busy),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic s, input logic [7:0] e_in, input logic [27:0] m_in,
                       output logic [31:0] res, output logic ov, output logic uf, output int lat);
    int e, p, k;
    logic [27:0] m;
    logic [25:0] q;
    e = e_in; m = m_in; ov = 0; uf = 0; p = -1;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    if (p < 0) begin res = 0; lat = 2; return; end
    lat = 3;
    if (p == 27) begin
      m = (m >> 1) | (m & 28'd1);
      e++;
      lat = 4;
      if (e == 255) begin res = {s, 8'hFF, 23'd0}; ov = 1; lat = 3; return; end
    end else if (p < 26) begin
      k = 26 - p;
      if (e <= k) begin res = {s, 31'd0}; uf = 1; lat = e + 2; return; end
      m = m << k;
      e -= k;
      lat = 3 + k;
    end
    q = 26'(m >> 3);
    if (m[2] && (m[1] || m[0] || q[0])) q++;
    if (q >= 26'(1 << 24)) begin
      q = q >> 1;
      e++;
      lat++;
      if (e == 255) begin res = {s, 8'hFF, 23'd0}; ov = 1; return; end
    end
    res = {s, 8'(e), q[22:0]};
  endtask

  task automatic run_op(input logic s, input logic [7:0] e, input logic [27:0] m, input bit poke);
    logic [31:0] res;
    logic ov, uf;
    int lat, c;
    bit got;
    model(s, e, m, res, ov, uf, lat);
    @(negedge clk);
    start = 1; sign_in = s; exp_in = e; mant_in = m;
    @(negedge clk);
    start = 0; sign_in = ~s; exp_in = ~e; mant_in = ~m;
    c = 0; got = 0;
    while (!got && c < 100) begin
      @(posedge clk); #1;
      c++;
      if (poke) start = (c == 1);
      if (done) got = 1;
      else check("busy_during", {31'd0, busy}, 32'd1);
    end
    start = 0;
    check("latency", 32'(c), 32'(lat));
    check("float_R", float_R, res);
    check("overflow", {31'd0, overflow}, {31'd0, ov});
    check("underflow", {31'd0, underflow}, {31'd0, uf});
    check("busy_at_done", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("single_done", {31'd0, done}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_float_R", float_R, 32'd0);
    check("rst_flags", {28'd0, done, busy, overflow, underflow}, 32'd0);
    @(negedge clk); rst = 0;
    run_op(0, 8'd127, 28'h4000000, 0);
    run_op(0, 8'd127, 28'h8000000, 0);
    run_op(1, 8'd130, 28'h0800000, 0);
    run_op(0, 8'd127, 28'h7FFFFFC, 0);
    run_op(0, 8'd127, 28'h4000004, 0);
    run_op(0, 8'd127, 28'h400000C, 0);
    run_op(0, 8'd254, 28'h8000000, 0);
    run_op(1, 8'd254, 28'h7FFFFFC, 0);
    run_op(1, 8'd5, 28'h0000000, 0);
    run_op(1, 8'd1, 28'h2000000, 0);
    run_op(0, 8'd3, 28'h0100000, 0);
    run_op(0, 8'd127, 28'h8000006, 1);
    run_op(1, 8'd40, 28'h0000123, 1);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] e;
      logic [27:0] m;
      e = (i % 4 == 0) ? 8'($urandom_range(1, 6)) : 8'($urandom_range(1, 254));
      m = 28'($urandom) >> $urandom_range(0, 27);
      run_op(1'($urandom_range(0, 1)), e, m, 0);
    end
    run_op(1, 8'd1, 28'h1000000, 0);
    @(negedge clk);
    start = 1; sign_in = 1; exp_in = 8'd130; mant_in = 28'h0800000;
    @(negedge clk); start = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    check("abort_float_R", float_R, 32'd0);
    check("abort_flags", {28'd0, done, busy, overflow, underflow}, 32'd0);
    @(negedge clk); rst = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    run_op(1, 8'd130, 28'h0800000, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_normalize_pack.md
# fp_normalize_pack

Multi-cycle normalize, round and pack stage of the FPU adder. It accepts the unnormalized sign, exponent and extended mantissa from the addition datapath, which is the output side of the big ALU. It normalizes one bit position per cycle, rounds to nearest-even, and packs the result into an IEEE-754 word. It is started by the control unit and returns a one-cycle done pulse, so it is the packing counterpart of the datapath's operand unpacking.

## Interface
- N_float, 32, packed float width
- N_exp, 8, exponent width
- N_mant, 23, stored fraction width
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  capture inputs when idle
- sign_in  in  1  result sign
- exp_in  in  N_exp  biased exponent of the larger operand; caller guarantees 1..2^N_exp-2
- mant_in  in  N_mant+5  bit positions:
  - [N_mant+4] carry
  - [N_mant+3] hidden
  - [N_mant+2:3] fraction
  - [2] guard, [1] round, [0] sticky
- float_R  out  N_float  packed result, held until next done
- done  out  1  one-cycle pulse, float_R valid
- busy  out  1  high from the cycle after start until done inclusive
- overflow  out  1  result is infinity; updated with done
- underflow  out  1  result flushed to zero; updated with done

One clock; reset is synchronous and active-high.

## Operation
- Internal registers: sign, exp (N_exp+1 bits), mant (N_mant+5 bits).
- States: IDLE, CHECK, SHIFT_R, SHIFT_L, ROUND, RENORM, DONE.
- IDLE: when start=1, capture the inputs and go to CHECK. start is ignored in all other states.
- CHECK, evaluated in this priority order:
  - mant==0: result +0 (exponent 0, fraction 0, sign 0), go to DONE.
  - carry=1: go to SHIFT_R.
  - hidden=0: go to SHIFT_L.
  - otherwise: go to ROUND.
- SHIFT_R, one cycle:
  - mant = mant>>1, with new bit0 = old bit1 | old bit0 (sticky preserved).
  - exp += 1.
  - If the new exp == 2^N_exp-1, produce infinity; otherwise go to ROUND.
- SHIFT_L, one bit per cycle:
  - If exp==1 and hidden=0, flush to zero: result is {sign, 0}, underflow=1, go to DONE.
  - Otherwise mant = mant<<1 (zero shifted in), exp -= 1.
  - Stay in SHIFT_L while the hidden bit is still 0; go to ROUND once hidden=1.
- ROUND, round to nearest-even:
  - inc = G & (R | S | mant[3]).
  - mant[N_mant+4:3] += inc.
  - Carry-out into bit N_mant+4 goes to RENORM; otherwise go to DONE.
- RENORM:
  - mant >>= 1, exp += 1.
  - exp == 2^N_exp-1 produces infinity; otherwise go to DONE.
- Infinity: result {sign, all-ones exponent, 0}, overflow=1, go to DONE.
- Pack format: {sign, exp[N_exp-1:0], mant[N_mant+2:3]}.
- DONE: drive done=1 with float_R, overflow and underflow updated, then go to IDLE.
- overflow and underflow are written at each done (cleared when not applicable).
- No denormal, NaN or special-input handling; special operands are resolved upstream.

## Timing
- Reset (rst=1 at an edge):
  - state goes to IDLE.
  - float_R=0, done=0, busy=0, overflow=0, underflow=0.
  - Reset mid-operation aborts without a done pulse.
- Cycle 0 is the edge where start is sampled. done is high in cycle L:
  - zero result: L=2.
  - already normalized: L=3.
  - carry: L=4.
  - k left shifts: L=3+k.
  - add 1 if RENORM is entered.
- Infinity from SHIFT_R or RENORM, and flush from SHIFT_L, go straight to DONE.
- The start that lands in the DONE cycle is ignored; the next accepted start is in the cycle after done.

## Test plan
All values use default parameters; mant_in is 28 bits.
- sign 0, exp 127, mant 0x4000000 -> float_R 0x3F800000; done at cycle 3; busy high in cycles 1-3.
- sign 0, exp 127, mant 0x8000000 (1+1) -> 0x40000000; done at cycle 4.
- sign 1, exp 130, mant 0x0800000 -> 3 left shifts -> 0xBF800000; done at cycle 6.
- Rounding:
  - exp 127, mant 0x7FFFFFC (all ones, G=1, LSB=1) -> RENORM -> 0x40000000; done at cycle 4.
  - exp 127, mant 0x4000004 (tie, LSB=0) -> 0x3F800000.
- Boundaries:
  - exp 254, mant 0x8000000 -> 0x7F800000, overflow=1.
  - mant 0 -> 0x00000000; done at cycle 2.
  - sign 1, exp 1, mant 0x2000000 -> 0x80000000, underflow=1.
- Control:
  - start pulsed while busy is ignored; exactly one done per accepted start.
  - rst asserted during SHIFT_L -> no done; all outputs 0 the next cycle; a fresh start completes normally.
